// File: rtl/seg7_scan_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner:
// display codes, anode select patterns and the blank segment pattern.
package seg7_scan_pkg;

    typedef logic [1:0] digit_idx_t;

    // Display codes beyond the decimal digits
    localparam logic [3:0] CODE_P     = 4'd10;
    localparam logic [3:0] CODE_UP    = 4'd11;
    localparam logic [3:0] CODE_DOWN  = 4'd12;
    localparam logic [3:0] CODE_DASH  = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low anode selects, one digit low at a time
    localparam logic [3:0] DIGIT_SEL0 = 4'b1110;
    localparam logic [3:0] DIGIT_SEL1 = 4'b1101;
    localparam logic [3:0] DIGIT_SEL2 = 4'b1011;
    localparam logic [3:0] DIGIT_SEL3 = 4'b0111;
    localparam logic [3:0] DIGIT_NONE = 4'b1111;

    // Active-low segments {g,f,e,d,c,b,a}, all off
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

    function automatic logic [3:0] digit_pattern(input digit_idx_t idx);
        logic [3:0] pat;
        case (idx)
            2'd0:    pat = DIGIT_SEL0;
            2'd1:    pat = DIGIT_SEL1;
            2'd2:    pat = DIGIT_SEL2;
            default: pat = DIGIT_SEL3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit display code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Code lookup; unused codes 14 and 15 are blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:      o_seg = 7'b1000000;
            4'd1:      o_seg = 7'b1111001;
            4'd2:      o_seg = 7'b0100100;
            4'd3:      o_seg = 7'b0110000;
            4'd4:      o_seg = 7'b0011001;
            4'd5:      o_seg = 7'b0010010;
            4'd6:      o_seg = 7'b0000010;
            4'd7:      o_seg = 7'b1111000;
            4'd8:      o_seg = 7'b0000000;
            4'd9:      o_seg = 7'b0010000;
            CODE_P:    o_seg = 7'b0001100;
            CODE_UP:   o_seg = 7'b1011100;
            CODE_DOWN: o_seg = 7'b1100011;
            CODE_DASH: o_seg = 7'b0111111;
            default:   o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner. A prescaler produces one tick per
// digit slot; the digit index advances on each tick. Input values are captured
// into shadow registers once per frame (on the 3->0 wrap tick) so a frame
// never mixes old and new data. DIGIT and DISPLAY are registered together.
// Optional blinking is compiled in when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] value0,
    input  logic [3:0] value1,
    input  logic [3:0] value2,
    input  logic [3:0] value3,
    input  logic [3:0] blink_mask,
    output logic [3:0] DIGIT,
    output logic [6:0] DISPLAY,
    output logic       frame_done
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_count;
    digit_idx_t    r_idx;
    logic [3:0]    r_shadow [4];
    logic [3:0]    r_digit;
    logic [6:0]    r_display;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_wrap;
    digit_idx_t    w_idx_next;
    logic [3:0]    w_value [4];
    logic [3:0]    w_code;
    logic [6:0]    w_seg;
    logic          w_hide;

    assign w_value[0] = value0;
    assign w_value[1] = value1;
    assign w_value[2] = value2;
    assign w_value[3] = value3;

    assign w_tick     = (r_count == CW'(SCAN_DIV - 1));
    assign w_wrap     = w_tick && (r_idx == 2'd3);
    assign w_idx_next = r_idx + 2'd1;

    // At the wrap the shadow is being loaded on this same edge, so take the
    // fresh input directly for digit 0 instead of the stale shadow.
    assign w_code = w_wrap ? w_value[0] : r_shadow[w_idx_next];

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // Prescaler: one tick every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (rst)         r_count <= '0;
        else if (w_tick) r_count <= '0;
        else             r_count <= r_count + CW'(1);
    end

    // Digit index advances once per tick, wrapping 3 -> 0
    always_ff @(posedge clk) begin
        if (rst)         r_idx <= 2'd0;
        else if (w_tick) r_idx <= w_idx_next;
    end

    // Shadow registers capture the inputs only at the frame wrap
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst)         r_shadow[gi] <= CODE_BLANK;
                else if (w_wrap) r_shadow[gi] <= w_value[gi];
            end
        end
    endgenerate

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_on;
    logic           w_blink_on_next;

    // Phase for the frame being entered; a whole frame uses one phase
    assign w_blink_on_next = (w_wrap && (r_blink_cnt == BCW'(BLINK_FRAMES - 1)))
                             ? ~r_blink_on : r_blink_on;
    assign w_hide = blink_mask[w_idx_next] && !w_blink_on_next;

    // Frame counter and blink phase, toggled every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_wrap) begin
            r_blink_on <= w_blink_on_next;
            if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) r_blink_cnt <= '0;
            else                                       r_blink_cnt <= r_blink_cnt + BCW'(1);
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
    assign w_hide         = 1'b0;
`endif

    // Registered outputs: anode and segments change together on a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit      <= DIGIT_NONE;
            r_display    <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                if (!en) begin
                    r_digit   <= DIGIT_NONE;
                    r_display <= SEG_BLANK;
                end else begin
                    r_digit   <= digit_pattern(w_idx_next);
                    r_display <= w_hide ? SEG_BLANK : w_seg;
                end
            end
        end
    end

    assign DIGIT      = r_digit;
    assign DISPLAY    = r_display;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (SCAN_DIV=4, BLINK_FRAMES=2).
// Reference model works from elapsed cycles since reset: slot k = n/SCAN_DIV,
// digit = k%4, frame = k/4; inputs are captured when a frame starts.
module tb_seg7_scan;

    localparam int SD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] value0, value1, value2, value3;
    logic [3:0] blink_mask;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value0     (value0),
        .value1     (value1),
        .value2     (value2),
        .value3     (value3),
        .blink_mask (blink_mask),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] c);
        case (c)
            4'd0:  return 7'b1000000;
            4'd1:  return 7'b1111001;
            4'd2:  return 7'b0100100;
            4'd3:  return 7'b0110000;
            4'd4:  return 7'b0011001;
            4'd5:  return 7'b0010010;
            4'd6:  return 7'b0000010;
            4'd7:  return 7'b1111000;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0010000;
            4'd10: return 7'b0001100;
            4'd11: return 7'b1011100;
            4'd12: return 7'b1100011;
            4'd13: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int slot_of(input int n);
        return (n / SD) % 4;
    endfunction

    // Blink phase for the frame that contains elapsed cycle n
    function automatic bit lit_phase(input int n);
        return (((n / SD) / 4) / BF) % 2 == 0;
    endfunction

    // Reference model state
    int         m_n;
    logic [3:0] m_sh [0:3];
    logic [3:0] m_digit;
    logic [6:0] m_disp;
    logic       m_fd;

    function automatic logic [6:0] model_seg(input int n, input logic [3:0] code,
                                             input logic [3:0] mask);
        logic [6:0] s;
        s = dec(code);
`ifdef SEG7_SCAN_BLINK_EN
        if (mask[slot_of(n)] && !lit_phase(n)) s = 7'b1111111;
`else
        if (mask[0] && 1'b0) s = 7'b1111111;
`endif
        return s;
    endfunction

    // Reference model, advanced on every clock edge
    always @(posedge clk) begin
        if (rst) begin
            m_n     <= 0;
            m_sh    <= '{4'd15, 4'd15, 4'd15, 4'd15};
            m_digit <= 4'b1111;
            m_disp  <= 7'b1111111;
            m_fd    <= 1'b0;
        end else begin
            m_n  <= m_n + 1;
            m_fd <= ((m_n + 1) % SD == 0) && (slot_of(m_n + 1) == 0);
            if (((m_n + 1) % SD == 0) && (slot_of(m_n + 1) == 0))
                m_sh <= '{value0, value1, value2, value3};
            if ((m_n + 1) % SD == 0) begin
                if (!en) begin
                    m_digit <= 4'b1111;
                    m_disp  <= 7'b1111111;
                end else begin
                    m_digit <= ~(4'b0001 << slot_of(m_n + 1));
                    m_disp  <= model_seg(m_n + 1,
                                         (slot_of(m_n + 1) == 0) ? value0 : m_sh[slot_of(m_n + 1)],
                                         blink_mask);
                end
            end
        end
    end

    task automatic test_reset();
        int guard;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: DIGIT=%b DISPLAY=%b fd=%b, want 1111 1111111 0",
                     DIGIT, DISPLAY, frame_done);
        end
        rst = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            n_tests++;
            if (DISPLAY !== 7'b1111111 || DIGIT !== m_digit || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL first_frame_blank n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b 1111111 %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_fd);
            end
        end while (m_n != 15 && guard < 30);
        $display("[TB] reset and blank first frame checked");
    endtask

    task automatic test_basic();
        logic [3:0] dig_tbl [4];
        logic [6:0] seg_tbl [4];
        int guard;
        dig_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tbl = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_n != 16 && guard < 40);
        if (m_n != 16) begin
            n_tests++; n_fail++;
            $display("FAIL basic_wait: frame wrap not reached, n=%0d want 16", m_n);
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (DIGIT !== dig_tbl[i/4] || DISPLAY !== seg_tbl[i/4] ||
                frame_done !== (i == 0)) begin
                n_fail++;
                $display("FAIL basic_scan cyc=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         i, DIGIT, DISPLAY, frame_done, dig_tbl[i/4], seg_tbl[i/4], (i == 0));
            end
        end
        $display("[TB] basic scan of 1,2,3,4 checked");
    endtask

    task automatic test_midframe();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (slot_of(m_n) != 1 && guard < 40);
        value0 = 4'd7;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL midframe n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
            n_tests++;
            if (m_n % 16 != 0 && DIGIT === 4'b1110 && DISPLAY !== 7'b1111001) begin
                n_fail++;
                $display("FAIL midframe_early n=%0d: DISPLAY=%b, want 1111001", m_n, DISPLAY);
            end
        end while (m_n % 16 != 0 && guard < 40);
        n_tests++;
        if (DIGIT !== 4'b1110 || DISPLAY !== 7'b1111000) begin
            n_fail++;
            $display("FAIL midframe_wrap: DIGIT=%b DISPLAY=%b, want 1110 1111000", DIGIT, DISPLAY);
        end
        $display("[TB] mid-frame value change checked");
    endtask

    task automatic test_enable();
        int last, pulses;
        bool_blank_check: begin end
        en = 1'b0;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL enable_off n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
            if (i >= SD) begin
                n_tests++;
                if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL enable_blank n=%0d: DIGIT=%b DISPLAY=%b, want 1111 1111111",
                             m_n, DIGIT, DISPLAY);
                end
            end
            if (frame_done === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (m_n - last != 16) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d cycles, want 16", m_n - last);
                    end
                end
                last = m_n;
                pulses++;
            end
        end
        n_tests++;
        if (pulses < 2) begin
            n_fail++;
            $display("FAIL frame_pulses: got %0d pulses in 40 cycles, want >=2", pulses);
        end
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL enable_resume n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
        end
        $display("[TB] enable blanking and resume checked");
    endtask

    task automatic test_codes();
        logic [6:0] seg_tbl [4];
        int guard;
        seg_tbl = '{7'b0001100, 7'b1011100, 7'b1100011, 7'b0111111};
        value0 = 4'd10; value1 = 4'd11; value2 = 4'd12; value3 = 4'd13;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_n % 16 != 0 && guard < 40);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (DISPLAY !== seg_tbl[i/4] || DIGIT !== ~(4'b0001 << (i/4))) begin
                n_fail++;
                $display("FAIL special_codes cyc=%0d: DIGIT=%b DISPLAY=%b, want %b %b",
                         i, DIGIT, DISPLAY, ~(4'b0001 << (i/4)), seg_tbl[i/4]);
            end
        end
        $display("[TB] special codes P/up/down/dash checked");
    endtask

    task automatic test_blink();
        logic [6:0] want;
        blink_mask = 4'b0001;
        value0 = 4'd8; value1 = 4'd5; value2 = 4'd0; value3 = 4'd9;
        for (int i = 0; i < 16 * 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL blink n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
            if (m_n % 16 == 0 && m_sh[0] == 4'd8) begin
`ifdef SEG7_SCAN_BLINK_EN
                want = lit_phase(m_n) ? 7'b0000000 : 7'b1111111;
`else
                want = 7'b0000000;
`endif
                n_tests++;
                if (DISPLAY !== want) begin
                    n_fail++;
                    $display("FAIL blink_digit0 frame=%0d: DISPLAY=%b, want %b",
                             m_n / 16, DISPLAY, want);
                end
            end
        end
        blink_mask = 4'b0000;
        $display("[TB] blink mask on digit 0 checked");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16 * 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL random n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
            if ($urandom_range(0, 7) == 0) begin
                value0 = 4'($urandom); value1 = 4'($urandom);
                value2 = 4'($urandom); value3 = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
        end
        en = 1'b1;
        $display("[TB] randomized values/enable/mask checked");
    endtask

    task automatic test_reset_mid();
        int guard;
        value0 = 4'd1; value1 = 4'd2; value2 = 4'd3; value3 = 4'd4;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(slot_of(m_n) == 2 && m_n % SD == 1) && guard < 40);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: DIGIT=%b DISPLAY=%b fd=%b, want 1111 1111111 0",
                     DIGIT, DISPLAY, frame_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (DIGIT !== m_digit || DISPLAY !== m_disp || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL reset_restart n=%0d: DIGIT=%b DISPLAY=%b fd=%b, want %b %b %b",
                         m_n, DIGIT, DISPLAY, frame_done, m_digit, m_disp, m_fd);
            end
            if (m_n == SD) begin
                n_tests++;
                if (DIGIT !== 4'b1101 || DISPLAY !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL reset_first_tick: DIGIT=%b DISPLAY=%b, want 1101 1111111",
                             DIGIT, DISPLAY);
                end
            end
        end
        $display("[TB] mid-frame reset checked");
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        value0 = 4'd1; value1 = 4'd2; value2 = 4'd3; value3 = 4'd4;
        blink_mask = 4'b0000;
        test_reset();
        test_basic();
        test_midframe();
        test_enable();
        test_codes();
        test_blink();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
